// File: rtl/csr_sequencer.sv
// -----------------------------------------------------------------------------
// csr_sequencer
//
// Runs one Zicsr instruction (CSRRW/CSRRS/CSRRC and their immediate forms) as a
// short multi-cycle sequence on the shared CSR port:
//   read the old CSR value -> write the new operand -> return the old value
//   to the register file.
// This block is the only master of the CSR address/strobe/bus lines.
//
// Optional feature (compile-time macro CSR_SEQ_RO_CHECK_EN):
//   When defined, a write aimed at the read-only CSR space (addr[11:10]==2'b11)
//   is turned into an illegal-instruction fault before any write strobe.
//   When undefined, no address check is done and the write is issued; the CSR
//   file decides what to do with it.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             launch an instruction (sampled only when idle)
//   funct3            001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
//   csr_addr          target CSR address
//   rs1_idx           rs1 index, or zimm for the immediate forms
//   rs1_val           rs1 value (unused for the immediate forms)
//   rd_idx            destination register
//   flush             abort the in-flight instruction
//   busy              sequence in flight
//   done / illegal    one-cycle completion / fault pulses (mutually exclusive)
//   rd_we/rd_waddr/rd_wdata   register-file write of the old CSR value
//   csr_addr_o        CSR address to the CSR file
//   csr_read          CSR read strobe
//   csr_write         CSR write strobe
//   csr_write_type    01 write, 10 set, 11 clear
//   csr_bus_o/_oe     write operand and its tri-state enable
//   csr_bus_i         resolved bus value (read data)
//   csr_invalid       CSR file rejects the current address
// -----------------------------------------------------------------------------
module csr_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [11:0]     csr_addr,
  input  logic [4:0]      rs1_idx,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [4:0]      rd_idx,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic            rd_we,
  output logic [4:0]      rd_waddr,
  output logic [XLEN-1:0] rd_wdata,
  output logic [11:0]     csr_addr_o,
  output logic            csr_read,
  output logic            csr_write,
  output logic [1:0]      csr_write_type,
  output logic [XLEN-1:0] csr_bus_o,
  output logic            csr_bus_oe,
  input  logic [XLEN-1:0] csr_bus_i,
  input  logic            csr_invalid
);

`ifdef CSR_SEQ_RO_CHECK_EN
  localparam bit RoCheck = 1'b1;
`else
  localparam bit RoCheck = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_FINISH,
    S_FAULT
  } state_t;

  state_t state_q, state_d;

  logic [1:0]      wtype_q;
  logic [11:0]     addr_q;
  logic [XLEN-1:0] operand_q;
  logic [XLEN-1:0] old_val_q;
  logic [4:0]      rd_idx_q;
  logic            do_read_q;
  logic            do_write_q;

  // Decode of the instruction presented with start.
  logic            in_legal;
  logic            in_rw;
  logic            in_do_read;
  logic            in_do_write;
  logic            in_ro_fault;
  logic [XLEN-1:0] in_operand;

  assign in_legal    = (funct3[1:0] != 2'b00);
  assign in_rw       = (funct3[1:0] == 2'b01);
  // CSRRW with rd=x0 must not read (no read side effects); set/clear with a
  // zero source must not write.
  assign in_do_read  = !(in_rw && (rd_idx == 5'd0));
  assign in_do_write = in_rw || (rs1_idx != 5'd0);
  assign in_operand  = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_val;
  assign in_ro_fault = RoCheck && in_do_write && (csr_addr[11:10] == 2'b11);

  logic ro_fault_q;
  assign ro_fault_q = RoCheck && do_write_q && (addr_q[11:10] == 2'b11);

  logic wr_raw;
  logic done_raw;
  logic illegal_raw;
  logic rd_we_raw;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    csr_read    = 1'b0;
    wr_raw      = 1'b0;
    done_raw    = 1'b0;
    illegal_raw = 1'b0;
    rd_we_raw   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!in_legal)        state_d = S_FAULT;
          else if (in_do_read)  state_d = S_READ;
          else if (in_ro_fault) state_d = S_FAULT;
          else                  state_d = S_WRITE;
        end
      end
      S_READ: begin
        csr_read = 1'b1;
        if (csr_invalid)     state_d = S_FAULT;
        else if (!do_write_q) state_d = S_FINISH;
        else if (ro_fault_q)  state_d = S_FAULT;
        else                  state_d = S_WRITE;
      end
      S_WRITE: begin
        wr_raw = 1'b1;
        // The strobe already went out; the CSR file blocks invalid writes.
        if (csr_invalid) state_d = S_FAULT;
        else             state_d = S_FINISH;
      end
      S_FINISH: begin
        done_raw  = 1'b1;
        rd_we_raw = do_read_q && (rd_idx_q != 5'd0);
        state_d   = S_IDLE;
      end
      S_FAULT: begin
        illegal_raw = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // A flush or reset cycle must not leave any side effect behind, so the
  // committing outputs are gated combinationally in that same cycle.
  logic kill;
  assign kill = flush | rst;

  assign csr_write      = wr_raw & ~kill;
  assign csr_bus_oe     = wr_raw & ~kill;
  assign done           = done_raw & ~kill;
  assign illegal        = illegal_raw & ~kill;
  assign rd_we          = rd_we_raw & ~kill;
  assign busy           = (state_q != S_IDLE);
  assign csr_addr_o     = addr_q;
  assign csr_write_type = wtype_q;
  assign csr_bus_o      = operand_q;
  assign rd_waddr       = rd_idx_q;
  assign rd_wdata       = old_val_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wtype_q    <= 2'b00;
      addr_q     <= '0;
      operand_q  <= '0;
      old_val_q  <= '0;
      rd_idx_q   <= '0;
      do_read_q  <= 1'b0;
      do_write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start && !flush) begin
        wtype_q    <= funct3[1:0];
        addr_q     <= csr_addr;
        operand_q  <= in_operand;
        rd_idx_q   <= rd_idx;
        do_read_q  <= in_do_read;
        do_write_q <= in_do_write;
      end
      if (state_q == S_READ && !csr_invalid) begin
        old_val_q <= csr_bus_i;
      end
    end
  end

endmodule

// File: tb/tb_csr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_csr_sequencer
//
// Self-checking bench for csr_sequencer. A small CSR file (mscratch 0x340,
// mtvec 0x305, read-only 0xF11, invalid 0x7FF, everything else reads 0) sits on
// the CSR port. Each instruction's expected timeline, bus traffic and results
// are derived from the Zicsr rules by a reference model held in the bench.
// Honours CSR_SEQ_RO_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_csr_sequencer;

  localparam int XLEN = 32;
  localparam logic [31:0] MSCRATCH_RST = 32'h1234_5678;
  localparam logic [31:0] MTVEC_RST    = 32'h0000_0100;
  localparam logic [31:0] RO_VAL       = 32'h0000_0A5A;

`ifdef CSR_SEQ_RO_CHECK_EN
  localparam bit RO_CHECK = 1'b1;
`else
  localparam bit RO_CHECK = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            start;
  logic [2:0]      funct3;
  logic [11:0]     csr_addr;
  logic [4:0]      rs1_idx;
  logic [XLEN-1:0] rs1_val;
  logic [4:0]      rd_idx;
  logic            flush;
  logic            busy;
  logic            done;
  logic            illegal;
  logic            rd_we;
  logic [4:0]      rd_waddr;
  logic [XLEN-1:0] rd_wdata;
  logic [11:0]     csr_addr_o;
  logic            csr_read;
  logic            csr_write;
  logic [1:0]      csr_write_type;
  logic [XLEN-1:0] csr_bus_o;
  logic            csr_bus_oe;
  logic [XLEN-1:0] csr_bus_i;
  logic            csr_invalid;

  csr_sequencer #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .funct3         (funct3),
    .csr_addr       (csr_addr),
    .rs1_idx        (rs1_idx),
    .rs1_val        (rs1_val),
    .rd_idx         (rd_idx),
    .flush          (flush),
    .busy           (busy),
    .done           (done),
    .illegal        (illegal),
    .rd_we          (rd_we),
    .rd_waddr       (rd_waddr),
    .rd_wdata       (rd_wdata),
    .csr_addr_o     (csr_addr_o),
    .csr_read       (csr_read),
    .csr_write      (csr_write),
    .csr_write_type (csr_write_type),
    .csr_bus_o      (csr_bus_o),
    .csr_bus_oe     (csr_bus_oe),
    .csr_bus_i      (csr_bus_i),
    .csr_invalid    (csr_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- CSR file model ----------------
  logic [31:0] mscratch_q;
  logic [31:0] mtvec_q;

  function automatic logic [31:0] apply_wr(logic [31:0] old, logic [31:0] d, logic [1:0] t);
    case (t)
      2'b01:   return d;
      2'b10:   return old | d;
      2'b11:   return old & ~d;
      default: return old;
    endcase
  endfunction

  always_comb begin
    csr_invalid = (csr_read || csr_write) && (csr_addr_o == 12'h7FF);
    csr_bus_i   = '0;
    if (csr_bus_oe) begin
      csr_bus_i = csr_bus_o;
    end else if (csr_read) begin
      case (csr_addr_o)
        12'h340: csr_bus_i = mscratch_q;
        12'h305: csr_bus_i = mtvec_q;
        12'hF11: csr_bus_i = RO_VAL;
        default: csr_bus_i = '0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      mscratch_q <= MSCRATCH_RST;
      mtvec_q    <= MTVEC_RST;
    end else if (csr_write && !csr_invalid) begin
      if (csr_addr_o == 12'h340) mscratch_q <= apply_wr(mscratch_q, csr_bus_o, csr_write_type);
      if (csr_addr_o == 12'h305) mtvec_q    <= apply_wr(mtvec_q, csr_bus_o, csr_write_type);
    end
  end

  // ---------------- checking ----------------
  int    total = 0;
  int    bad   = 0;
  string cur   = "";

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", cur, tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          illegal;
    int          end_cycle;
    int          read_cycle;
    int          write_cycle;
    logic [31:0] wbus;
    logic [1:0]  wtype;
    bit          rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    bit          csr_changes;
    logic [31:0] new_val;
  } exp_t;

  typedef struct {
    bit          ended;
    bit          illegal;
    bit          both;
    int          end_cycle;
    int          read_cycle;
    int          n_read;
    int          write_cycle;
    int          n_write;
    logic [31:0] wbus;
    logic [1:0]  wtype;
    bit          rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    bit          contention;
    bit          busy_gap;
  } obs_t;

  logic [31:0] ref_mscratch;
  logic [31:0] ref_mtvec;

  function automatic logic [31:0] ref_value(logic [11:0] a, logic [31:0] ms, logic [31:0] mt);
    case (a)
      12'h340: return ms;
      12'h305: return mt;
      12'hF11: return RO_VAL;
      default: return 32'h0;
    endcase
  endfunction

  // Timeline counted in cycles after the launching edge: reads take one slot,
  // writes one slot, and the done/illegal pulse appears in the slot after.
  function automatic exp_t model(logic [2:0] f3, logic [11:0] a, logic [4:0] rs1,
                                 logic [31:0] v, logic [4:0] rd, logic [31:0] old);
    exp_t        e;
    logic [1:0]  kind;
    logic [31:0] op;
    bit          rw, reads, writes, inval, ro;
    int          t;
    e = '{default: 0};
    kind = f3[1:0];
    if (kind == 2'b00) begin
      e.illegal = 1'b1;
      e.end_cycle = 1;
      return e;
    end
    op     = f3[2] ? {27'b0, rs1} : v;
    rw     = (kind == 2'b01);
    reads  = !(rw && rd == 5'd0);
    writes = rw || (rs1 != 5'd0);
    inval  = (a == 12'h7FF);
    ro     = (a[11:10] == 2'b11);
    t = 0;
    if (reads) begin
      t = 1;
      e.read_cycle = 1;
      if (inval) begin
        e.illegal = 1'b1;
        e.end_cycle = 2;
        return e;
      end
    end
    if (RO_CHECK && writes && ro) begin
      e.illegal = 1'b1;
      e.end_cycle = t + 1;
      return e;
    end
    if (writes) begin
      t = t + 1;
      e.write_cycle = t;
      e.wbus  = op;
      e.wtype = kind;
      if (inval) begin
        e.illegal = 1'b1;
        e.end_cycle = t + 1;
        return e;
      end
    end
    e.end_cycle = t + 1;
    e.rd_we     = reads && (rd != 5'd0);
    e.rd_addr   = rd;
    e.rd_data   = old;
    if (writes) begin
      e.csr_changes = (a == 12'h340) || (a == 12'h305);
      case (kind)
        2'b01:   e.new_val = op;
        2'b10:   e.new_val = old | op;
        default: e.new_val = old & ~op;
      endcase
    end
    return e;
  endfunction

  // Launch one instruction, watch it to completion and compare against the
  // model. With noisy set, start/funct3/operands are scrambled while busy.
  task automatic run_instr(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1,
                           input logic [31:0] v, input logic [4:0] rd, input bit noisy,
                           output obs_t o);
    exp_t e;
    e = model(f3, a, rs1, v, rd, ref_value(a, ref_mscratch, ref_mtvec));
    o = '{default: 0};
    @(negedge clk);
    start = 1'b1; funct3 = f3; csr_addr = a; rs1_idx = rs1; rs1_val = v; rd_idx = rd;
    @(negedge clk);
    for (int c = 1; c <= 8 && !o.ended; c++) begin
      if (csr_read) begin
        o.n_read++;
        if (o.read_cycle == 0) o.read_cycle = c;
      end
      if (csr_write) begin
        o.n_write++;
        if (o.write_cycle == 0) begin
          o.write_cycle = c;
          o.wbus  = csr_bus_o;
          o.wtype = csr_write_type;
        end
      end
      if (csr_read && csr_bus_oe) o.contention = 1'b1;
      if (!busy) o.busy_gap = 1'b1;
      if (done || illegal) begin
        o.ended     = 1'b1;
        o.end_cycle = c;
        o.illegal   = illegal;
        o.both      = done && illegal;
        o.rd_we     = rd_we;
        o.rd_addr   = rd_waddr;
        o.rd_data   = rd_wdata;
      end
      if (noisy && !o.ended) begin
        start    = 1'($urandom_range(0, 1));
        funct3   = 3'($urandom);
        csr_addr = 12'($urandom);
        rs1_idx  = 5'($urandom);
        rs1_val  = $urandom;
        rd_idx   = 5'($urandom);
      end else begin
        start = 1'b0;
      end
      if (!o.ended) @(negedge clk);
    end
    start = 1'b0;
    check("ended", o.ended, 1'b1);
    check("illegal_kind", o.illegal, e.illegal);
    check("end_cycle", o.end_cycle, e.end_cycle);
    check("read_cycle", o.read_cycle, e.read_cycle);
    check("n_read", o.n_read, (e.read_cycle != 0) ? 1 : 0);
    check("write_cycle", o.write_cycle, e.write_cycle);
    check("n_write", o.n_write, (e.write_cycle != 0) ? 1 : 0);
    if (e.write_cycle != 0) begin
      check("wbus", o.wbus, e.wbus);
      check("wtype", o.wtype, e.wtype);
    end
    check("rd_we", o.rd_we, e.rd_we);
    if (e.rd_we) begin
      check("rd_waddr", o.rd_addr, e.rd_addr);
      check("rd_wdata", o.rd_data, e.rd_data);
    end
    check("done_and_illegal", o.both, 1'b0);
    check("bus_contention", o.contention, 1'b0);
    check("busy_gap", o.busy_gap, 1'b0);
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_pulses", {done, illegal, rd_we}, 3'b000);
    if (e.csr_changes) begin
      if (a == 12'h340) ref_mscratch = e.new_val;
      else              ref_mtvec    = e.new_val;
    end
    check("mscratch", mscratch_q, ref_mscratch);
    check("mtvec", mtvec_q, ref_mtvec);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    obs_t        o;
    logic [11:0] addr_pick [5];
    addr_pick[0] = 12'h340; addr_pick[1] = 12'h305; addr_pick[2] = 12'hF11;
    addr_pick[3] = 12'h7FF; addr_pick[4] = 12'h300;

    rst = 1'b1; start = 1'b0; funct3 = '0; csr_addr = '0; rs1_idx = '0;
    rs1_val = '0; rd_idx = '0; flush = 1'b0;
    ref_mscratch = MSCRATCH_RST;
    ref_mtvec    = MTVEC_RST;
    repeat (3) @(negedge clk);

    cur = "reset";
    check("busy", busy, 1'b0);
    check("pulses", {done, illegal, rd_we}, 3'b000);
    check("strobes", {csr_read, csr_write, csr_bus_oe}, 3'b000);
    check("rd_wdata", rd_wdata, 32'h0);
    rst = 1'b0;

    cur = "csrrs_rd0_rs0";
    run_instr(3'b010, 12'h340, 5'd0, 32'hFFFF_FFFF, 5'd0, 1'b0, o);
    check("latency2", o.end_cycle, 2);
    check("no_write", o.n_write, 0);

    cur = "csrrci_zimm5";
    run_instr(3'b111, 12'h340, 5'd5, 32'hFFFF_FFFF, 5'd3, 1'b0, o);
    check("wtype11", o.wtype, 2'b11);
    check("bus5", o.wbus, 32'h0000_0005);
    check("x3", o.rd_data, 32'h1234_5678);

    cur = "csrrw_x5";
    run_instr(3'b001, 12'h340, 5'd7, 32'hCAFE_F00D, 5'd5, 1'b0, o);
    check("read_c1", o.read_cycle, 1);
    check("write_c2", o.write_cycle, 2);
    check("done_c3", o.end_cycle, 3);
    check("bus", o.wbus, 32'hCAFE_F00D);
    check("x5", o.rd_data, 32'h1234_5678);
    check("mscratch_new", mscratch_q, 32'hCAFE_F00D);

    cur = "csrrw_rd0_write_only";
    run_instr(3'b001, 12'h305, 5'd1, 32'h0000_2000, 5'd0, 1'b0, o);
    check("latency2", o.end_cycle, 2);

    cur = "funct3_100";
    run_instr(3'b100, 12'h340, 5'd1, 32'h1, 5'd1, 1'b0, o);
    check("illegal_c1", o.illegal, 1'b1);
    check("no_strobes", o.n_read + o.n_write, 0);

    cur = "invalid_7ff";
    run_instr(3'b001, 12'h7FF, 5'd1, 32'h55, 5'd4, 1'b0, o);
    check("illegal", o.illegal, 1'b1);
    check("rd_we0", o.rd_we, 1'b0);

    cur = "ro_f11";
    run_instr(3'b001, 12'hF11, 5'd1, 32'h77, 5'd2, 1'b0, o);
    check("ro_outcome", o.illegal, RO_CHECK);

    cur = "start_while_busy";
    run_instr(3'b011, 12'h305, 5'd9, 32'h0000_0100, 5'd6, 1'b1, o);

    // Flush during WRITE: strobe forced low, no completion afterwards.
    cur = "flush_write";
    @(negedge clk);
    start = 1'b1; funct3 = 3'b001; csr_addr = 12'h340; rs1_idx = 5'd2;
    rs1_val = 32'hDEAD_BEEF; rd_idx = 5'd5;
    @(negedge clk);
    start = 1'b0;
    check("in_read", csr_read, 1'b1);
    @(negedge clk);
    check("in_write", csr_write, 1'b1);
    flush = 1'b1;
    #1;
    check("write_forced", csr_write, 1'b0);
    check("oe_forced", csr_bus_oe, 1'b0);
    check("done_forced", done, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    check("idle_after", busy, 1'b0);
    check("no_rd_we", rd_we, 1'b0);
    check("no_done", done, 1'b0);
    check("mscratch_kept", mscratch_q, ref_mscratch);

    cur = "flush_with_start";
    start = 1'b1; flush = 1'b1; funct3 = 3'b001;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("ignored", busy, 1'b0);

    // Reset in the WRITE cycle: no strobe, idle afterwards.
    cur = "rst_mid";
    start = 1'b1; funct3 = 3'b001; csr_addr = 12'h305; rs1_idx = 5'd3;
    rs1_val = 32'h0BAD_0BAD; rd_idx = 5'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("no_write_strobe", csr_write, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ref_mscratch = MSCRATCH_RST;
    ref_mtvec    = MTVEC_RST;
    check("idle", busy, 1'b0);
    check("mtvec_reset", mtvec_q, MTVEC_RST);

    for (int n = 0; n < 200; n++) begin
      logic [4:0] r1, rdi;
      cur = $sformatf("rand%0d", n);
      r1  = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      rdi = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      run_instr(3'($urandom), addr_pick[$urandom_range(0, 4)], r1, $urandom, rdi,
                1'($urandom_range(0, 1)), o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
